// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and limits for the memory-game timers
package game_pkg;

    typedef enum logic [1:0] {
        GT_IDLE    = 2'd0,
        GT_RUN     = 2'd1,
        GT_PAUSE   = 2'd2,
        GT_EXPIRED = 2'd3
    } gt_state_t;

    localparam int GT_MAX_SECS = 99;

endpackage

// File: rtl/bin_to_bcd99.sv
// rtl/bin_to_bcd99.sv - combinational 7-bit binary (0..99) to two BCD digits
module bin_to_bcd99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin % 7'd10);
    end

endmodule

// File: rtl/game_timer.sv
// rtl/game_timer.sv - countdown game clock with BCD digits and expiry pulse
// Optional registered warning output enabled by GAME_TIMER_WARN_EN.
module game_timer
    import game_pkg::*;
#(
    parameter int START_SECS = 30,
    parameter int BONUS_SECS = 5,
    parameter int WARN_SECS  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic       add_bonus,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       running,
    output logic       time_up,
`ifdef GAME_TIMER_WARN_EN
    output logic       warn,
`endif
    output logic       expired
);

    gt_state_t  state;
    logic [6:0] count;
    logic [7:0] sum;
    logic [6:0] upd;

    // Full 8-bit sum before clamping so bonus+tick at 97 still lands on 99.
    always_comb begin
        sum = {1'b0, count} + (add_bonus ? 8'(BONUS_SECS) : 8'd0) - (tick ? 8'd1 : 8'd0);
        upd = (sum > 8'(GT_MAX_SECS)) ? 7'(GT_MAX_SECS) : sum[6:0];
    end

`ifdef GAME_TIMER_WARN_EN
    function automatic logic in_warn(input logic [6:0] c);
        return (c >= 7'd1) && (c <= 7'(WARN_SECS));
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= GT_IDLE;
            count   <= 7'(START_SECS);
            running <= 1'b0;
            time_up <= 1'b0;
            expired <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
            warn    <= 1'b0;
`endif
        end else begin
            time_up <= 1'b0;
            if (load) begin
                state   <= GT_IDLE;
                count   <= 7'(START_SECS);
                running <= 1'b0;
                expired <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
                warn    <= 1'b0;
`endif
            end else begin
                case (state)
                    GT_IDLE: begin
                        if (start) begin
                            state   <= GT_RUN;
                            running <= 1'b1;
`ifdef GAME_TIMER_WARN_EN
                            warn    <= in_warn(count);
`endif
                        end
                    end
                    GT_RUN: begin
                        if (pause) begin
                            state   <= GT_PAUSE;
                            running <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
                            warn    <= 1'b0;
`endif
                        end else if (upd == 7'd0) begin
                            state   <= GT_EXPIRED;
                            count   <= 7'd0;
                            running <= 1'b0;
                            expired <= 1'b1;
                            time_up <= 1'b1;
`ifdef GAME_TIMER_WARN_EN
                            warn    <= 1'b0;
`endif
                        end else begin
                            count   <= upd;
`ifdef GAME_TIMER_WARN_EN
                            warn    <= in_warn(upd);
`endif
                        end
                    end
                    GT_PAUSE: begin
                        // pause wins over a simultaneous start
                        if (start && !pause) begin
                            state   <= GT_RUN;
                            running <= 1'b1;
`ifdef GAME_TIMER_WARN_EN
                            warn    <= in_warn(count);
`endif
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    bin_to_bcd99 u_bcd (
        .bin  (count),
        .tens (secs_tens),
        .ones (secs_ones)
    );

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - self-checking bench for game_timer (table, directed, random)
module tb_game_timer;

    localparam int START = 30;
    localparam int BONUS = 5;
    localparam int WARNS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, add_bonus = 1'b0;
    logic [3:0] secs_tens, secs_ones;
    logic       running, time_up, expired;
`ifdef GAME_TIMER_WARN_EN
    logic       warn;
`endif

    always #5 clk = ~clk;

    game_timer #(.START_SECS(START), .BONUS_SECS(BONUS), .WARN_SECS(WARNS)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .load      (load),
        .start     (start),
        .pause     (pause),
        .add_bonus (add_bonus),
        .secs_tens (secs_tens),
        .secs_ones (secs_ones),
        .running   (running),
        .time_up   (time_up),
`ifdef GAME_TIMER_WARN_EN
        .warn      (warn),
`endif
        .expired   (expired)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 run, 2 pause, 3 expired
    int m_st  = 0;
    int m_cnt = START;
    int m_tu  = 0;
    int m_wrn = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_cnt();
        return int'(secs_tens) * 10 + int'(secs_ones);
    endfunction

    task automatic model_step();
        int n;
        m_tu = 0;
        if (!rst || load) begin
            m_st  = 0;
            m_cnt = START;
        end else if (m_st == 0) begin
            if (start) m_st = 1;
        end else if (m_st == 1) begin
            if (pause) m_st = 2;
            else begin
                n = m_cnt + (add_bonus ? BONUS : 0) - (tick ? 1 : 0);
                if (n > 99) n = 99;
                if (n <= 0) begin
                    m_cnt = 0;
                    m_st  = 3;
                    m_tu  = 1;
                end else m_cnt = n;
            end
        end else if (m_st == 2) begin
            if (start && !pause) m_st = 1;
        end
        m_wrn = (m_st == 1 && m_cnt >= 1 && m_cnt <= WARNS) ? 1 : 0;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".tens"},    int'(secs_tens), m_cnt / 10);
        check({tag, ".ones"},    int'(secs_ones), m_cnt % 10);
        check({tag, ".running"}, int'(running),   (m_st == 1) ? 1 : 0);
        check({tag, ".time_up"}, int'(time_up),   m_tu);
        check({tag, ".expired"}, int'(expired),   (m_st == 3) ? 1 : 0);
`ifdef GAME_TIMER_WARN_EN
        check({tag, ".warn"},    int'(warn),      m_wrn);
`endif
    endtask

    task automatic drive(input logic r, input logic l, input logic s, input logic p,
                         input logic b, input logic t);
        rst = r; load = l; start = s; pause = p; add_bonus = b; tick = t;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic apply(input string tag, input logic r, input logic l, input logic s,
                         input logic p, input logic b, input logic t);
        drive(r, l, s, p, b, t);
        compare_model(tag);
    endtask

    typedef struct {
        logic rst, load, start, pause, bonus, tick;
        int   cnt, run, tu, exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b0, 0, 0, 0, 0, 0, 30, 0, 0, 0};
        vecs[1]  = '{1'b1, 0, 1, 0, 0, 0, 30, 1, 0, 0};
        vecs[2]  = '{1'b1, 0, 0, 0, 0, 1, 29, 1, 0, 0};
        vecs[3]  = '{1'b1, 0, 0, 1, 0, 0, 29, 0, 0, 0};
        vecs[4]  = '{1'b1, 0, 0, 0, 0, 1, 29, 0, 0, 0};
        vecs[5]  = '{1'b1, 0, 0, 0, 1, 0, 29, 0, 0, 0};
        vecs[6]  = '{1'b1, 0, 1, 1, 0, 0, 29, 0, 0, 0};
        vecs[7]  = '{1'b1, 0, 1, 0, 0, 0, 29, 1, 0, 0};
        vecs[8]  = '{1'b1, 0, 0, 0, 1, 1, 33, 1, 0, 0};
        vecs[9]  = '{1'b1, 0, 0, 0, 1, 0, 38, 1, 0, 0};
        vecs[10] = '{1'b1, 0, 1, 0, 0, 1, 37, 1, 0, 0};
        vecs[11] = '{1'b1, 1, 1, 1, 0, 0, 30, 0, 0, 0};
        vecs[12] = '{1'b1, 0, 0, 0, 0, 1, 30, 0, 0, 0};
        vecs[13] = '{1'b1, 0, 1, 0, 0, 0, 30, 1, 0, 0};
        vecs[14] = '{1'b1, 0, 0, 0, 0, 1, 29, 1, 0, 0};
        vecs[15] = '{1'b0, 1, 0, 0, 0, 1, 30, 0, 0, 0};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].start, vecs[i].pause,
                  vecs[i].bonus, vecs[i].tick);
            check($sformatf("vec%0d.count", i),   dut_cnt(),      vecs[i].cnt);
            check($sformatf("vec%0d.running", i), int'(running),  vecs[i].run);
            check($sformatf("vec%0d.time_up", i), int'(time_up),  vecs[i].tu);
            check($sformatf("vec%0d.expired", i), int'(expired),  vecs[i].exp);
        end

        // Full countdown from 30 to expiry
        apply("cd_rst", 1'b0, 0, 0, 0, 0, 0);
        apply("cd_start", 1'b1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            apply("cd_tick", 1'b1, 0, 0, 0, 0, 1);
            check($sformatf("cd_count%0d", i), dut_cnt(), 30 - i);
        end
        check("cd_time_up_pulse", int'(time_up), 1);
        check("cd_expired", int'(expired), 1);
        apply("cd_after", 1'b1, 0, 0, 0, 0, 0);
        check("cd_time_up_clear", int'(time_up), 0);
        for (int i = 0; i < 3; i++) apply("cd_extra", 1'b1, 0, 0, 0, 0, 1);
        check("cd_hold_zero", dut_cnt(), 0);

        // Expired ignores start/bonus; load recovers
        apply("ex_ign", 1'b1, 0, 1, 0, 1, 0);
        check("ex_ign_cnt", dut_cnt(), 0);
        check("ex_ign_exp", int'(expired), 1);
        apply("ex_load", 1'b1, 1, 0, 0, 0, 0);
        check("ex_load_cnt", dut_cnt(), 30);
        check("ex_load_exp", int'(expired), 0);
        check("ex_load_run", int'(running), 0);

        // Pause at 12
        apply("pz_start", 1'b1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 18; i++) apply("pz_tick", 1'b1, 0, 0, 0, 0, 1);
        check("pz_at12", dut_cnt(), 12);
        apply("pz_pause", 1'b1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) apply("pz_held", 1'b1, 0, 0, 0, 0, 1);
        check("pz_hold12", dut_cnt(), 12);
        apply("pz_resume", 1'b1, 0, 1, 0, 0, 0);
        apply("pz_tick2", 1'b1, 0, 0, 0, 0, 1);
        check("pz_at11", dut_cnt(), 11);

        // Saturation and bonus+tick
        apply("sat_load", 1'b1, 1, 0, 0, 0, 0);
        apply("sat_start", 1'b1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) apply("sat_bonus", 1'b1, 0, 0, 0, 1, 0);
        check("sat_99", dut_cnt(), 99);
        apply("sat_t1", 1'b1, 0, 0, 0, 0, 1);
        apply("sat_t2", 1'b1, 0, 0, 0, 0, 1);
        check("sat_97", dut_cnt(), 97);
        apply("sat_b97", 1'b1, 0, 0, 0, 1, 0);
        check("sat_97_to_99", dut_cnt(), 99);
        for (int i = 0; i < 79; i++) apply("sat_down", 1'b1, 0, 0, 0, 0, 1);
        check("sat_20", dut_cnt(), 20);
        apply("sat_bt", 1'b1, 0, 0, 0, 1, 1);
        check("sat_bt_24", dut_cnt(), 24);

        // Reset mid-run at 07
        apply("mr_load", 1'b1, 1, 0, 0, 0, 0);
        apply("mr_start", 1'b1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 23; i++) apply("mr_tick", 1'b1, 0, 0, 0, 0, 1);
        check("mr_at7", dut_cnt(), 7);
        apply("mr_rst", 1'b0, 0, 0, 0, 0, 1);
        check("mr_cnt30", dut_cnt(), 30);
        check("mr_idle", int'(running), 0);
        check("mr_no_tu", int'(time_up), 0);
        apply("mr_after", 1'b1, 0, 0, 0, 0, 1);
        check("mr_no_tu2", int'(time_up), 0);

`ifdef GAME_TIMER_WARN_EN
        apply("wn_start", 1'b1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 24; i++) apply("wn_tick", 1'b1, 0, 0, 0, 0, 1);
        check("wn_at6", int'(warn), 0);
        apply("wn_tick5", 1'b1, 0, 0, 0, 0, 1);
        check("wn_rise", int'(warn), 1);
        apply("wn_pause", 1'b1, 0, 0, 1, 0, 0);
        check("wn_pause0", int'(warn), 0);
        apply("wn_resume", 1'b1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply("wn_end", 1'b1, 0, 0, 0, 0, 1);
        check("wn_expired0", int'(warn), 0);
        check("wn_expired", int'(expired), 1);
`endif

        // Randomized run against the model
        apply("rnd_init", 1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            apply("rnd",
                  ($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
